// File: rtl/dtree_feature_sequencer.sv
// dtree_feature_sequencer: collects a serial feature frame, holds the selected feature on a combinational tree and returns its class on a valid/ready channel
module dtree_feature_sequencer #(
  parameter int N_FEAT   = 16,
  parameter int FEAT_W   = 8,
  parameter int CLASS_W  = 4,
  parameter int SEL_FEAT = 16,
  parameter int CNT_W    = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic [FEAT_W-1:0]  s_data,
  input  logic               s_last,
  output logic [FEAT_W-1:0]  tree_x,
  input  logic [CLASS_W-1:0] tree_class,
  output logic               m_valid,
  input  logic               m_ready,
  output logic [CLASS_W-1:0] m_class,
  output logic               m_err,
  output logic [CNT_W-1:0]   frame_cnt
);
  localparam int IW = $clog2(N_FEAT + 3);
  typedef enum logic [1:0] {COLLECT, EVAL, HOLD} state_t;
  state_t        state;
  logic [IW-1:0] idx;
  logic [IW-1:0] cnt;
  logic          err_pending;
  logic          acc;
  // ready depends only on state and rst, never on s_valid
  assign s_ready = (state == COLLECT) && !rst;
  assign acc     = s_valid && s_ready;
  assign cnt     = idx + 1'b1;
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= COLLECT;
      idx         <= '0;
      err_pending <= 1'b0;
      tree_x      <= '0;
      m_valid     <= 1'b0;
      m_class     <= '0;
      m_err       <= 1'b0;
      frame_cnt   <= '0;
    end else begin
      case (state)
        COLLECT: if (acc) begin
          idx <= (idx == IW'(N_FEAT + 1)) ? idx : cnt;
          if (cnt == IW'(SEL_FEAT)) tree_x <= s_data;
          if (s_last) begin
            err_pending <= cnt != IW'(N_FEAT);
            state       <= EVAL;
          end
        end
        EVAL: begin
          m_class <= tree_class;
          m_err   <= err_pending;
          m_valid <= 1'b1;
          idx     <= '0;
          state   <= HOLD;
        end
        HOLD: if (m_ready) begin
          m_valid   <= 1'b0;
          frame_cnt <= frame_cnt + 1'b1;
          state     <= COLLECT;
        end
        default: state <= COLLECT;
      endcase
    end
  end
endmodule

// File: tb/tb_dtree_feature_sequencer.sv
// tb_dtree_feature_sequencer: random frames against a frame-level model of feature selection, length error and result counting
module tb_dtree_feature_sequencer;
  localparam int N = 16, SEL = 16;
  logic       clk = 0, rst = 1, s_valid = 0, s_last = 0, m_ready = 0;
  logic [7:0] s_data = 0;
  logic       s_ready, m_valid, m_err;
  logic [7:0] tree_x;
  logic [3:0] tree_class, m_class, frame_cnt;
  int         vectors = 0, miscompares = 0, cyc = 0, exp_cnt = 0;
  logic [7:0] exp_x = 0;
  typedef struct {int c; logic [3:0] cls; logic err; logic [7:0] x; logic [3:0] cnt;} res_t;
  res_t mon[$];

  dtree_feature_sequencer #(.N_FEAT(N), .FEAT_W(8), .CLASS_W(4), .SEL_FEAT(SEL), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .tree_x(tree_x), .tree_class(tree_class), .m_valid(m_valid), .m_ready(m_ready),
    .m_class(m_class), .m_err(m_err), .frame_cnt(frame_cnt));

  assign tree_class = tree_x[7:4];
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (!rst && m_valid && m_ready) mon.push_back('{cyc, m_class, m_err, tree_x, frame_cnt});

  // frame-level reference: selected feature survives only if the frame reaches it
  function automatic void model_frame(input logic [7:0] f[$], output logic [3:0] cls, output logic err);
    if (f.size() >= SEL) exp_x = f[SEL-1];
    err = f.size() != N;
    cls = exp_x[7:4];
  endfunction

  task automatic put_beat(input logic [7:0] d, input logic l, input int gap);
    int n;
    repeat (gap) begin s_valid = 0; @(posedge clk); #1; end
    s_valid = 1; s_data = d; s_last = l; n = 0;
    @(negedge clk);
    while (!s_ready && n < 300) begin @(posedge clk); #1; @(negedge clk); n++; end
    if (!s_ready) begin vectors++; miscompares++; $display("FAIL beat_accept timeout got s_ready=0 exp 1"); end
    @(posedge clk); #1;
    s_valid = 0; s_last = 0;
  endtask

  task automatic send_frame(input logic [7:0] f[$], input int maxgap);
    for (int i = 0; i < f.size(); i++) put_beat(f[i], i == f.size() - 1, int'($urandom_range(0, maxgap)));
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!m_valid && n < 500) begin @(posedge clk); #1; n++; end
    vectors++;
    if (!m_valid) begin miscompares++; $display("FAIL m_valid_timeout got 0 exp 1"); end
  endtask

  task automatic test_reset;
    repeat (3) @(posedge clk);
    #1;
    vectors++; if (s_ready !== 1'b0) begin miscompares++; $display("FAIL rst_s_ready_during got %b exp 0", s_ready); end
    rst = 0; #1;
    vectors++; if (s_ready !== 1'b1) begin miscompares++; $display("FAIL rst_s_ready_after got %b exp 1", s_ready); end
    vectors++; if ({tree_x, m_valid, m_class, m_err, frame_cnt} !== 18'd0)
      begin miscompares++; $display("FAIL rst_outputs got x=%h v=%b c=%h e=%b n=%h exp all 0", tree_x, m_valid, m_class, m_err, frame_cnt); end
  endtask

  task automatic test_nominal;
    logic [7:0] f[$]; logic [3:0] cls; logic err; int n;
    for (int i = 1; i <= 15; i++) f.push_back(8'(i * 4));
    f.push_back(8'hB3);
    model_frame(f, cls, err);
    m_ready = 1;
    for (int i = 0; i < 15; i++) put_beat(f[i], 0, int'($urandom_range(0, 2)));
    s_valid = 1; s_data = 8'hB3; s_last = 1; n = 0;
    do begin @(posedge clk); #1; n++; s_valid = 0; s_last = 0; end while (!m_valid && n < 20);
    vectors++; if (n != 2) begin miscompares++; $display("FAIL nom_latency got %0d exp 2", n); end
    vectors++; if (m_class !== cls) begin miscompares++; $display("FAIL nom_class got %h exp %h", m_class, cls); end
    vectors++; if (m_err !== err) begin miscompares++; $display("FAIL nom_err got %b exp %b", m_err, err); end
    vectors++; if (tree_x !== exp_x) begin miscompares++; $display("FAIL nom_tree_x got %h exp %h", tree_x, exp_x); end
    @(posedge clk); #1; exp_cnt++;
    vectors++; if (m_valid !== 1'b0) begin miscompares++; $display("FAIL nom_valid_drop got %b exp 0", m_valid); end
    vectors++; if (frame_cnt !== 4'(exp_cnt)) begin miscompares++; $display("FAIL nom_frame_cnt got %0d exp %0d", frame_cnt, 4'(exp_cnt)); end
  endtask

  task automatic test_backpressure;
    logic [7:0] f[$]; logic [3:0] cls; logic err; int n;
    for (int i = 0; i < 15; i++) f.push_back(8'($urandom));
    f.push_back(8'h40);
    model_frame(f, cls, err);
    m_ready = 0;
    send_frame(f, 1);
    wait_valid(n);
    s_valid = 1; s_data = 8'h11; s_last = 0;
    repeat (10) begin
      @(posedge clk); #1;
      vectors++; if (m_valid !== 1'b1) begin miscompares++; $display("FAIL bp_valid got %b exp 1", m_valid); end
      vectors++; if (m_class !== cls) begin miscompares++; $display("FAIL bp_class got %h exp %h", m_class, cls); end
      vectors++; if (m_err !== err) begin miscompares++; $display("FAIL bp_err got %b exp %b", m_err, err); end
      vectors++; if (s_ready !== 1'b0) begin miscompares++; $display("FAIL bp_s_ready got %b exp 0", s_ready); end
      vectors++; if (tree_x !== exp_x) begin miscompares++; $display("FAIL bp_tree_x got %h exp %h", tree_x, exp_x); end
    end
    m_ready = 1;
    @(posedge clk); #1; exp_cnt++;
    vectors++; if (m_valid !== 1'b0) begin miscompares++; $display("FAIL bp_release_valid got %b exp 0", m_valid); end
    vectors++; if (frame_cnt !== 4'(exp_cnt)) begin miscompares++; $display("FAIL bp_frame_cnt got %0d exp %0d", frame_cnt, 4'(exp_cnt)); end
    vectors++; if (s_ready !== 1'b1) begin miscompares++; $display("FAIL bp_release_ready got %b exp 1", s_ready); end
  endtask

  task automatic test_short;
    logic [7:0] f[$]; logic [3:0] cls; logic err; int n;
    f.push_back(8'h11);
    for (int i = 1; i < 10; i++) f.push_back(8'($urandom));
    model_frame(f, cls, err);
    send_frame(f, 1);
    wait_valid(n);
    vectors++; if (m_class !== cls) begin miscompares++; $display("FAIL short_class got %h exp %h", m_class, cls); end
    vectors++; if (m_err !== err) begin miscompares++; $display("FAIL short_err got %b exp %b", m_err, err); end
    vectors++; if (tree_x !== exp_x) begin miscompares++; $display("FAIL short_tree_x got %h exp %h", tree_x, exp_x); end
    @(posedge clk); #1; exp_cnt++;
  endtask

  task automatic test_long;
    logic [7:0] f[$]; logic [3:0] cls; logic err; int n;
    for (int i = 0; i < 15; i++) f.push_back(8'($urandom));
    f.push_back(8'h7F);
    repeat (4) f.push_back(8'hFF);
    model_frame(f, cls, err);
    send_frame(f, 1);
    wait_valid(n);
    vectors++; if (m_class !== cls) begin miscompares++; $display("FAIL long_class got %h exp %h", m_class, cls); end
    vectors++; if (m_err !== err) begin miscompares++; $display("FAIL long_err got %b exp %b", m_err, err); end
    vectors++; if (tree_x !== exp_x) begin miscompares++; $display("FAIL long_tree_x got %h exp %h", tree_x, exp_x); end
    @(posedge clk); #1; exp_cnt++;
    vectors++; if (frame_cnt !== 4'(exp_cnt)) begin miscompares++; $display("FAIL long_frame_cnt got %0d exp %0d", frame_cnt, 4'(exp_cnt)); end
  endtask

  task automatic test_random;
    logic [7:0] f[$], all[$], ex[8]; logic [3:0] ecls[8]; logic eerr[8]; int lens[8]; int base; bit done;
    mon.delete(); base = exp_cnt; done = 0;
    for (int k = 0; k < 8; k++) begin
      lens[k] = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 20)) : N;
      f.delete();
      for (int j = 0; j < lens[k]; j++) f.push_back(8'($urandom));
      model_frame(f, ecls[k], eerr[k]);
      ex[k] = exp_x;
      foreach (f[j]) all.push_back(f[j]);
    end
    fork
      begin
        int p, w;
        p = 0; w = 0;
        for (int k = 0; k < 8; k++)
          for (int j = 0; j < lens[k]; j++) begin put_beat(all[p], j == lens[k] - 1, int'($urandom_range(0, 2))); p++; end
        while (mon.size() < 8 && w < 3000) begin @(posedge clk); #1; w++; end
        done = 1;
      end
      begin
        while (!done) begin @(posedge clk); #1; m_ready = 1'($urandom_range(0, 1)); end
      end
    join
    m_ready = 1; exp_cnt += 8;
    vectors++; if (mon.size() != 8) begin miscompares++; $display("FAIL rand_count got %0d exp 8", mon.size()); end
    for (int k = 0; k < 8 && k < mon.size(); k++) begin
      vectors++; if (mon[k].cls !== ecls[k]) begin miscompares++; $display("FAIL rand_class[%0d] got %h exp %h", k, mon[k].cls, ecls[k]); end
      vectors++; if (mon[k].err !== eerr[k]) begin miscompares++; $display("FAIL rand_err[%0d] got %b exp %b", k, mon[k].err, eerr[k]); end
      vectors++; if (mon[k].x !== ex[k]) begin miscompares++; $display("FAIL rand_tree_x[%0d] got %h exp %h", k, mon[k].x, ex[k]); end
      vectors++; if (mon[k].cnt !== 4'(base + k)) begin miscompares++; $display("FAIL rand_cnt[%0d] got %0d exp %0d", k, mon[k].cnt, 4'(base + k)); end
    end
  endtask

  task automatic test_throughput;
    logic [7:0] f[$]; logic [3:0] ecls[17]; logic eerr[17];
    rst = 1; repeat (2) @(posedge clk); #1; rst = 0;
    exp_x = 0; exp_cnt = 0; mon.delete(); m_ready = 1;
    for (int k = 0; k < 17; k++) begin
      f.delete();
      for (int j = 0; j < N; j++) f.push_back(8'($urandom));
      model_frame(f, ecls[k], eerr[k]);
      send_frame(f, 0);
    end
    repeat (6) @(posedge clk);
    #1; exp_cnt = 17;
    vectors++; if (mon.size() != 17) begin miscompares++; $display("FAIL tput_count got %0d exp 17", mon.size()); end
    for (int k = 0; k < 17 && k < mon.size(); k++) begin
      vectors++; if (mon[k].cls !== ecls[k] || mon[k].err !== eerr[k])
        begin miscompares++; $display("FAIL tput_result[%0d] got %h/%b exp %h/%b", k, mon[k].cls, mon[k].err, ecls[k], eerr[k]); end
      vectors++; if (mon[k].cnt !== 4'(k)) begin miscompares++; $display("FAIL tput_cnt[%0d] got %0d exp %0d", k, mon[k].cnt, 4'(k)); end
      if (k > 0) begin
        vectors++; if (mon[k].c - mon[k-1].c != N + 2)
          begin miscompares++; $display("FAIL tput_period[%0d] got %0d exp %0d", k, mon[k].c - mon[k-1].c, N + 2); end
      end
    end
    vectors++; if (frame_cnt !== 4'(exp_cnt)) begin miscompares++; $display("FAIL tput_wrap got %0d exp %0d", frame_cnt, 4'(exp_cnt)); end
  endtask

  task automatic test_reset_mid;
    logic [7:0] f[$]; logic [3:0] cls; logic err; int n;
    m_ready = 1;
    for (int i = 0; i < 8; i++) put_beat(8'($urandom), 0, 0);
    rst = 1; #1;
    vectors++; if (s_ready !== 1'b0) begin miscompares++; $display("FAIL mid_s_ready_during got %b exp 0", s_ready); end
    @(posedge clk); #1; rst = 0; #1;
    exp_x = 0; exp_cnt = 0;
    vectors++; if ({tree_x, m_valid, m_class, m_err, frame_cnt} !== 18'd0)
      begin miscompares++; $display("FAIL mid_outputs got x=%h v=%b c=%h e=%b n=%h exp all 0", tree_x, m_valid, m_class, m_err, frame_cnt); end
    vectors++; if (s_ready !== 1'b1) begin miscompares++; $display("FAIL mid_s_ready_after got %b exp 1", s_ready); end
    for (int i = 0; i < 15; i++) f.push_back(8'($urandom));
    f.push_back(8'h25);
    model_frame(f, cls, err);
    send_frame(f, 1);
    wait_valid(n);
    vectors++; if (m_class !== cls) begin miscompares++; $display("FAIL mid_class got %h exp %h", m_class, cls); end
    vectors++; if (m_err !== err) begin miscompares++; $display("FAIL mid_err got %b exp %b", m_err, err); end
    @(posedge clk); #1; exp_cnt++;
    vectors++; if (frame_cnt !== 4'(exp_cnt)) begin miscompares++; $display("FAIL mid_frame_cnt got %0d exp %0d", frame_cnt, 4'(exp_cnt)); end
  endtask

  initial begin
    test_reset;
    test_nominal;
    test_backpressure;
    test_short;
    test_long;
    test_random;
    test_throughput;
    test_reset_mid;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired got running exp finished");
    $fatal(1);
  end
endmodule
